// File: rtl/dbuf_lane_scheduler.sv
// dbuf_lane_scheduler
// Credit-based round-robin frame scheduler sitting behind the double buffer's
// push port. The buffer is throttled through stall_o. Every accepted beat is
// forwarded one cycle later on a shared registered bus, tagged with a one-hot
// lane strobe. A lane owns FRAME_LEN_g consecutive beats per grant and is only
// eligible for a grant while it holds at least one credit.
module dbuf_lane_scheduler #(
  parameter int DW_g         = 64,
  parameter int LANES_g      = 4,
  parameter int FRAME_LEN_g  = 16,
  parameter int CREDIT_MAX_g = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       enable_i,
  input  logic                       flush_i,
  input  logic                       push_valid_i,
  input  logic [DW_g-1:0]            push_data_i,
  output logic                       stall_o,
  input  logic [LANES_g-1:0]         credit_rtn_i,
  output logic [LANES_g-1:0]         lane_valid_o,
  output logic [DW_g-1:0]            lane_data_o,
  output logic                       lane_last_o,
  output logic [$clog2(LANES_g)-1:0] lane_sel_o,
  output logic                       busy_o,
  output logic                       err_o
);

  localparam int LW_c = $clog2(LANES_g);
  localparam int CW_c = $clog2(CREDIT_MAX_g + 1);
  localparam int BW_c = (FRAME_LEN_g > 1) ? $clog2(FRAME_LEN_g) : 1;
  localparam logic [CW_c-1:0] CMAX_c = CW_c'(CREDIT_MAX_g);
  localparam logic [BW_c-1:0] LAST_c = BW_c'(FRAME_LEN_g - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_STREAM
  } state_t;

  state_t             state_q;
  logic [LW_c-1:0]    ptr_q;
  logic [LW_c-1:0]    sel_q;
  logic [BW_c-1:0]    beat_cnt_q;
  logic [LANES_g-1:0] lane_valid_q;
  logic [DW_g-1:0]    lane_data_q;
  logic               lane_last_q;
  logic               err_q;

  logic [LANES_g-1:0] has_credit;
  logic [LANES_g-1:0] rtn_err_vec;
  logic               stall;
  logic               accept;
  logic               drop;
  logic               frame_done;
  logic               found;
  logic [LW_c-1:0]    next_lane;
  logic [LW_c-1:0]    cand;

  // Stall depends only on registered state plus the enable level, never on push_valid_i.
  assign stall      = !((state_q == ST_STREAM) && enable_i && has_credit[ptr_q]);
  assign accept     = push_valid_i && !stall;
  assign drop       = push_valid_i && stall;
  assign frame_done = accept && (beat_cnt_q == LAST_c);

  // Per-lane credit counters. Credits follow consumer returns even while the
  // scheduler is disabled, so no return pulse is ever lost.
  for (genvar gi = 0; gi < LANES_g; gi++) begin : g_lane
    logic [CW_c-1:0] credit_q;
    logic [CW_c-1:0] credit_d;
    logic            consume;
    logic            rtn_err;

    assign consume = accept && (ptr_q == LW_c'(gi));

    // A beat and a return landing in the same cycle cancel; a return to a full lane is an error.
    always_comb begin
      credit_d = credit_q;
      rtn_err  = 1'b0;
      if (consume && !credit_rtn_i[gi]) begin
        credit_d = credit_q - CW_c'(1);
      end else if (credit_rtn_i[gi] && !consume) begin
        if (credit_q == CMAX_c) begin
          rtn_err = 1'b1;
        end else begin
          credit_d = credit_q + CW_c'(1);
        end
      end
    end

    // Credit register, full after reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        credit_q <= CMAX_c;
      end else begin
        credit_q <= credit_d;
      end
    end

    assign has_credit[gi]  = (credit_q != '0);
    assign rtn_err_vec[gi] = rtn_err;
  end

  // Round-robin search starting one past the current pointer; the lowest offset wins.
  always_comb begin
    found     = 1'b0;
    next_lane = ptr_q;
    cand      = '0;
    for (int i = LANES_g; i >= 1; i--) begin
      cand = LW_c'((int'(ptr_q) + i) % LANES_g);
      if (has_credit[cand]) begin
        found     = 1'b1;
        next_lane = cand;
      end
    end
  end

  // Control FSM with registered lane outputs and sticky error flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      ptr_q        <= LW_c'(LANES_g - 1);
      sel_q        <= '0;
      beat_cnt_q   <= '0;
      lane_valid_q <= '0;
      lane_data_q  <= '0;
      lane_last_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      lane_valid_q <= '0;
      lane_last_q  <= 1'b0;
      if (accept) begin
        lane_valid_q <= LANES_g'(1) << ptr_q;
        lane_data_q  <= push_data_i;
        // A flushed frame never reports a final beat.
        lane_last_q  <= frame_done && !flush_i;
      end
      if (drop || (|rtn_err_vec)) begin
        err_q <= 1'b1;
      end
      if (enable_i) begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_SELECT;
          end
          ST_SELECT: begin
            if (found) begin
              ptr_q      <= next_lane;
              sel_q      <= next_lane;
              beat_cnt_q <= '0;
              state_q    <= ST_STREAM;
            end
          end
          ST_STREAM: begin
            if (flush_i || frame_done) begin
              beat_cnt_q <= '0;
              state_q    <= ST_SELECT;
            end else if (accept) begin
              beat_cnt_q <= beat_cnt_q + BW_c'(1);
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign stall_o      = stall;
  assign lane_valid_o = lane_valid_q;
  assign lane_data_o  = lane_data_q;
  assign lane_last_o  = lane_last_q;
  assign lane_sel_o   = sel_q;
  assign busy_o       = (state_q == ST_STREAM);
  assign err_o        = err_q;

endmodule

// File: tb/tb_dbuf_lane_scheduler.sv
// tb_dbuf_lane_scheduler
// Directed bench: one task per scenario. Two instances share all inputs; "a_"
// is the default configuration (8 credits), "b_" uses 32 credits per lane.
module tb_dbuf_lane_scheduler;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        flush;
  logic        push_valid;
  logic [63:0] push_data;
  logic [3:0]  credit_rtn;

  logic        a_stall, a_last, a_busy, a_err;
  logic [3:0]  a_valid;
  logic [63:0] a_data;
  logic [1:0]  a_sel;
  logic        b_stall, b_last, b_busy, b_err;
  logic [3:0]  b_valid;
  logic [63:0] b_data;
  logic [1:0]  b_sel;

  int checks   = 0;
  int failures = 0;

  dbuf_lane_scheduler #(.DW_g(64), .LANES_g(4), .FRAME_LEN_g(16), .CREDIT_MAX_g(8)) dut (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .flush_i(flush),
    .push_valid_i(push_valid), .push_data_i(push_data), .stall_o(a_stall),
    .credit_rtn_i(credit_rtn), .lane_valid_o(a_valid), .lane_data_o(a_data),
    .lane_last_o(a_last), .lane_sel_o(a_sel), .busy_o(a_busy), .err_o(a_err)
  );

  dbuf_lane_scheduler #(.DW_g(64), .LANES_g(4), .FRAME_LEN_g(16), .CREDIT_MAX_g(32)) dut32 (
    .clk_i(clk), .rst_i(rst), .enable_i(enable), .flush_i(flush),
    .push_valid_i(push_valid), .push_data_i(push_data), .stall_o(b_stall),
    .credit_rtn_i(credit_rtn), .lane_valid_o(b_valid), .lane_data_o(b_data),
    .lane_last_o(b_last), .lane_sel_o(b_sel), .busy_o(b_busy), .err_o(b_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] beat_data(input int n);
    beat_data = {32'hDA7A0000 + 32'(n), ~32'(n * 7)};
  endfunction

  function automatic int lane_of(input logic [3:0] v);
    lane_of = -1;
    for (int i = 0; i < 4; i++) begin
      if (v == 4'(1 << i)) lane_of = i;
    end
  endfunction

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0; flush = 1'b0; push_valid = 1'b0; push_data = '0; credit_rtn = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; flush = 1'b0; push_valid = 1'b0; push_data = '0; credit_rtn = '0;
    @(negedge clk);
    checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL reset_stall got=%0b exp=1", a_stall); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", a_busy); end
    checks++; if (a_sel !== 2'd0) begin failures++; $display("FAIL reset_sel got=%0d exp=0", a_sel); end
    checks++; if (a_last !== 1'b0) begin failures++; $display("FAIL reset_last got=%0b exp=0", a_last); end
    checks++; if (a_data !== 64'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", a_data); end
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL disabled_stall cyc=%0d got=%0b exp=1", c, a_stall); end
      checks++; if (a_valid !== 4'b0000) begin failures++; $display("FAIL disabled_valid cyc=%0d got=%0b exp=0000", c, a_valid); end
      checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL disabled_err cyc=%0d got=%0b exp=0", c, a_err); end
    end
    enable = 1'b1;
    @(negedge clk);
    checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL select_stall got=%0b exp=1", a_stall); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL select_busy got=%0b exp=0", a_busy); end
    @(negedge clk);
    checks++; if (a_stall !== 1'b0) begin failures++; $display("FAIL stream_stall got=%0b exp=0", a_stall); end
    checks++; if (a_sel !== 2'd0) begin failures++; $display("FAIL stream_sel got=%0d exp=0", a_sel); end
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL stream_busy got=%0b exp=1", a_busy); end
    $display("test_reset done");
  endtask

  // 32-credit instance: 64 beats, four full frames in lane order, 1-cycle gaps.
  task automatic test_round_robin();
    int pushed = 0, seen = 0, stall_cyc = 0, run = 0, max_run = 0, exp_lane;
    logic exp_last;
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 300 && seen < 64; c++) begin
      @(negedge clk);
      if (b_valid !== 4'b0000) begin
        exp_lane = seen / 16;
        exp_last = (seen % 16 == 15);
        $display("rr beat %0d lane=%0d last=%0b data=%0h", seen, lane_of(b_valid), b_last, b_data);
        checks++; if (b_valid !== 4'(1 << exp_lane)) begin failures++; $display("FAIL rr_lane beat=%0d got=%0b exp=%0b", seen, b_valid, 4'(1 << exp_lane)); end
        checks++; if (b_data !== beat_data(seen)) begin failures++; $display("FAIL rr_data beat=%0d got=%0h exp=%0h", seen, b_data, beat_data(seen)); end
        checks++; if (b_last !== exp_last) begin failures++; $display("FAIL rr_last beat=%0d got=%0b exp=%0b", seen, b_last, exp_last); end
        seen++;
      end
      if (pushed > 0 && pushed < 64) begin
        if (b_stall) begin
          stall_cyc++; run++;
          if (run > max_run) max_run = run;
        end else begin
          run = 0;
        end
      end
      credit_rtn = b_valid;
      if (!b_stall && pushed < 64) begin
        push_valid = 1'b1; push_data = beat_data(pushed); pushed++;
      end else begin
        push_valid = 1'b0;
      end
    end
    push_valid = 1'b0; credit_rtn = '0;
    checks++; if (seen !== 64) begin failures++; $display("FAIL rr_count got=%0d exp=64", seen); end
    checks++; if (stall_cyc !== 3) begin failures++; $display("FAIL rr_gap_total got=%0d exp=3", stall_cyc); end
    checks++; if (max_run !== 1) begin failures++; $display("FAIL rr_gap_len got=%0d exp=1", max_run); end
    checks++; if (b_err !== 1'b0) begin failures++; $display("FAIL rr_err got=%0b exp=0", b_err); end
  endtask

  // No returns: lane0 drains its 8 credits, then a single return buys one beat.
  task automatic test_credit_stall();
    int pushed = 0, lane0 = 0, other = 0, lasts = 0, extra = 0;
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (a_valid === 4'b0001) begin lane0++; $display("cs beat %0d lane=0", lane0); end
      else if (a_valid !== 4'b0000) other++;
      if (a_last) lasts++;
      push_valid = !a_stall; push_data = beat_data(pushed);
      if (!a_stall) pushed++;
    end
    checks++; if (lane0 !== 8) begin failures++; $display("FAIL cs_lane0_beats got=%0d exp=8", lane0); end
    checks++; if (other !== 0) begin failures++; $display("FAIL cs_other_beats got=%0d exp=0", other); end
    checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL cs_stall_hold got=%0b exp=1", a_stall); end
    checks++; if (a_busy !== 1'b1) begin failures++; $display("FAIL cs_busy got=%0b exp=1", a_busy); end
    credit_rtn = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      credit_rtn = 4'b0000;
      if (a_valid === 4'b0001) begin extra++; $display("cs extra beat lane=0 last=%0b", a_last); end
      else if (a_valid !== 4'b0000) other++;
      if (a_last) lasts++;
      push_valid = !a_stall; push_data = beat_data(pushed);
      if (!a_stall) pushed++;
    end
    push_valid = 1'b0;
    checks++; if (extra !== 1) begin failures++; $display("FAIL cs_extra_beats got=%0d exp=1", extra); end
    checks++; if (lasts !== 0) begin failures++; $display("FAIL cs_last got=%0d exp=0", lasts); end
    checks++; if (other !== 0) begin failures++; $display("FAIL cs_other_after got=%0d exp=0", other); end
    checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL cs_err got=%0b exp=0", a_err); end
  endtask

  // Lane1 is drained to 0 during its first frame, skipped, then revived by one return.
  task automatic test_skip_empty_lane();
    int order [9];
    int exp_order [9] = '{0, 1, 2, 3, 0, 2, 3, 0, 1};
    int pushed = 0, nframes = 0, lane1_beats = 0, lane;
    logic new_frame = 1'b1, extra_done = 1'b0;
    logic [3:0] rtn;
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 600 && nframes < 9; c++) begin
      @(negedge clk);
      rtn = '0;
      if (a_valid !== 4'b0000) begin
        lane = lane_of(a_valid);
        if (new_frame) begin
          if (nframes < 9) order[nframes] = lane;
          $display("skip frame %0d lane=%0d", nframes, lane);
          nframes++;
        end
        new_frame = a_last;
        if (lane == 1) begin
          if (lane1_beats < 8) rtn[1] = 1'b1;
          lane1_beats++;
        end else if (lane >= 0) begin
          rtn[lane] = 1'b1;
        end
        if (lane == 3 && nframes == 7 && !extra_done) begin
          rtn[1] = 1'b1; extra_done = 1'b1;
        end
      end
      credit_rtn = rtn;
      push_valid = !a_stall; push_data = beat_data(pushed);
      if (!a_stall) pushed++;
    end
    credit_rtn = '0; push_valid = 1'b0;
    checks++; if (nframes !== 9) begin failures++; $display("FAIL skip_frames got=%0d exp=9", nframes); end
    for (int i = 0; i < 9 && i < nframes; i++) begin
      checks++; if (order[i] !== exp_order[i]) begin failures++; $display("FAIL skip_order frame=%0d got=%0d exp=%0d", i, order[i], exp_order[i]); end
    end
    checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL skip_err got=%0b exp=0", a_err); end
  endtask

  // Simultaneous beat+return, return to a full lane, push while stalled.
  task automatic test_credit_edges();
    int pushed = 0, seen = 0, lasts = 0, stalls = 0;
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 60 && seen < 16; c++) begin
      @(negedge clk);
      if (a_valid === 4'b0001) begin seen++; $display("ce beat %0d lane=0 last=%0b", seen, a_last); end
      if (a_last) lasts++;
      if (pushed > 0 && pushed < 16 && a_stall) stalls++;
      if (!a_stall && pushed < 16) begin
        push_valid = 1'b1; credit_rtn = 4'b0001; push_data = beat_data(pushed); pushed++;
      end else begin
        push_valid = 1'b0; credit_rtn = 4'b0000;
      end
    end
    push_valid = 1'b0; credit_rtn = 4'b0000;
    checks++; if (seen !== 16) begin failures++; $display("FAIL ce_beats got=%0d exp=16", seen); end
    checks++; if (stalls !== 0) begin failures++; $display("FAIL ce_midframe_stall got=%0d exp=0", stalls); end
    checks++; if (lasts !== 1) begin failures++; $display("FAIL ce_last got=%0d exp=1", lasts); end
    checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL ce_err_before got=%0b exp=0", a_err); end
    credit_rtn = 4'b0001;
    @(negedge clk);
    credit_rtn = 4'b0000;
    checks++; if (a_err !== 1'b1) begin failures++; $display("FAIL ce_full_return_err got=%0b exp=1", a_err); end

    do_reset();
    checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL ce_err_cleared got=%0b exp=0", a_err); end
    push_valid = 1'b1; push_data = 64'hDEAD_BEEF_0BAD_F00D;
    @(negedge clk);
    push_valid = 1'b0;
    checks++; if (a_valid !== 4'b0000) begin failures++; $display("FAIL ce_drop_valid got=%0b exp=0000", a_valid); end
    checks++; if (a_err !== 1'b1) begin failures++; $display("FAIL ce_drop_err got=%0b exp=1", a_err); end
  endtask

  // Flush on beat 5 of lane0, then async reset in the middle of the lane2 frame.
  task automatic test_flush_and_reset();
    int pushed = 0, seen = 0, lane2_seen = 0, exp_lane, lane, first_lane = -1;
    logic exp_last;
    do_reset();
    enable = 1'b1;
    for (int c = 0; c < 200 && lane2_seen < 5; c++) begin
      @(negedge clk);
      flush = 1'b0;
      credit_rtn = a_valid;
      if (a_valid !== 4'b0000) begin
        lane = lane_of(a_valid);
        exp_lane = (seen < 5) ? 0 : (seen < 21) ? 1 : 2;
        exp_last = (seen == 20);
        $display("fl beat %0d lane=%0d last=%0b", seen, lane, a_last);
        checks++; if (lane !== exp_lane) begin failures++; $display("FAIL fl_lane beat=%0d got=%0d exp=%0d", seen, lane, exp_lane); end
        checks++; if (a_last !== exp_last) begin failures++; $display("FAIL fl_last beat=%0d got=%0b exp=%0b", seen, a_last, exp_last); end
        checks++; if (a_data !== beat_data(seen)) begin failures++; $display("FAIL fl_data beat=%0d got=%0h exp=%0h", seen, a_data, beat_data(seen)); end
        if (lane == 2) lane2_seen++;
        seen++;
      end
      if (!a_stall) begin
        push_valid = 1'b1; push_data = beat_data(pushed); pushed++;
        flush = (pushed == 5);
      end else begin
        push_valid = 1'b0;
      end
    end
    checks++; if (lane2_seen !== 5) begin failures++; $display("FAIL fl_reach_lane2 got=%0d exp=5", lane2_seen); end
    checks++; if (a_err !== 1'b0) begin failures++; $display("FAIL fl_err got=%0b exp=0", a_err); end
    rst = 1'b1; enable = 1'b0; flush = 1'b0; push_valid = 1'b0; credit_rtn = '0;
    #1;
    checks++; if (a_valid !== 4'b0000) begin failures++; $display("FAIL rst_valid got=%0b exp=0000", a_valid); end
    checks++; if (a_stall !== 1'b1) begin failures++; $display("FAIL rst_stall got=%0b exp=1", a_stall); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", a_busy); end
    checks++; if (a_sel !== 2'd0) begin failures++; $display("FAIL rst_sel got=%0d exp=0", a_sel); end
    checks++; if (a_data !== 64'd0) begin failures++; $display("FAIL rst_data got=%0h exp=0", a_data); end
    @(negedge clk);
    rst = 1'b0; enable = 1'b1; pushed = 0;
    for (int c = 0; c < 20 && first_lane < 0; c++) begin
      @(negedge clk);
      if (a_valid !== 4'b0000) first_lane = lane_of(a_valid);
      push_valid = !a_stall; push_data = beat_data(pushed);
      if (!a_stall) pushed++;
    end
    push_valid = 1'b0;
    $display("fl after reset first lane=%0d", first_lane);
    checks++; if (first_lane !== 0) begin failures++; $display("FAIL rst_first_lane got=%0d exp=0", first_lane); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_credit_stall();
    test_skip_empty_lane();
    test_credit_edges();
    test_flush_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
